// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared CPU bus definitions: region codes, OAM DMA state encodings,
// address-map constants and the address decoder used by the bus blocks.
package cpu_bus_ctrl_pkg;

   localparam logic [15:0] RAM_LAST = 16'h1FFF;
   localparam logic [15:0] PPU_LAST = 16'h3FFF;
   localparam logic [15:0] PRG_BASE = 16'h8000;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_RAM,
      RGN_PPU,
      RGN_PRG,
      RGN_DMA
   } region_e;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_ALIGN,
      DMA_RD,
      DMA_WR
   } dma_state_e;

   function automatic region_e decode_region(input logic [15:0] addr,
                                             input logic [15:0] dma_reg_addr);
      if (addr <= RAM_LAST) return RGN_RAM;
      if (addr <= PPU_LAST) return RGN_PPU;
      if (addr == dma_reg_addr) return RGN_DMA;
      if (addr >= PRG_BASE) return RGN_PRG;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/cpu_bus_ctrl_oam_dma.sv
// OAM DMA sequencer: one alignment cycle, then 256 read/write pairs copying
// page {page, idx} into sprite OAM.
module oam_dma
   import cpu_bus_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [7:0]  page_i,
   output logic        busy_o,
   output logic        rd_o,
   output logic        oam_we_o,
   output logic [7:0]  oam_addr_o,
   output logic [15:0] src_addr_o
);

   dma_state_e state_d, state_q;
   logic [7:0] idx_d, idx_q;
   logic [7:0] page_d, page_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= DMA_IDLE;
         idx_q   <= '0;
         page_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         page_q  <= page_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      page_d  = page_q;
      unique case (state_q)
         DMA_IDLE: begin
            if (start_i) begin
               state_d = DMA_ALIGN;
               page_d  = page_i;
               idx_d   = '0;
            end
         end
         DMA_ALIGN: state_d = DMA_RD;
         DMA_RD:    state_d = DMA_WR;
         DMA_WR: begin
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == 8'hFF) ? DMA_IDLE : DMA_RD;
         end
         default:   state_d = DMA_IDLE;
      endcase
   end

   // Strobe gated by reset so an aborted transfer never writes during the reset cycle.
   assign busy_o     = (state_q != DMA_IDLE);
   assign rd_o       = (state_q == DMA_RD);
   assign oam_we_o   = rst_ni && (state_q == DMA_WR);
   assign oam_addr_o = idx_q;
   assign src_addr_o = {page_q, idx_q};

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: address decode, 1-cycle read-return mux with open-bus
// latch, and arbitration between CPU accesses and the OAM DMA engine.
module cpu_bus_ctrl
   import cpu_bus_ctrl_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int unsigned RAM_AW       = 11
) (
   input  logic              clk_ph1,
   input  logic              rst,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_rw,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_rdy,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [14:0]       prg_addr,
   input  logic [7:0]        prg_rdata,
   output logic              ppu_cs,
   output logic              ppu_we,
   output logic [2:0]        ppu_reg,
   output logic [7:0]        ppu_wdata,
   input  logic [7:0]        ppu_rdata,
   output logic              oam_we,
   output logic [7:0]        oam_addr,
   output logic [7:0]        oam_wdata
);

   region_e     cpu_rgn, src_rgn;
   region_e     rgn_d, rgn_q;
   logic [7:0]  rd_mux;
   logic [7:0]  ob_d, ob_q;
   logic        cpu_wr;
   logic        dma_start;
   logic        dma_busy;
   logic        dma_rd;
   logic [15:0] src_addr;

   oam_dma u_oam_dma (
      .clk_i      (clk_ph1),
      .rst_ni     (rst),
      .start_i    (dma_start),
      .page_i     (cpu_wdata),
      .busy_o     (dma_busy),
      .rd_o       (dma_rd),
      .oam_we_o   (oam_we),
      .oam_addr_o (oam_addr),
      .src_addr_o (src_addr)
   );

   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         rgn_q <= RGN_NONE;
         ob_q  <= '0;
      end else begin
         rgn_q <= rgn_d;
         ob_q  <= ob_d;
      end
   end

   always_comb begin
      cpu_rgn = decode_region(cpu_addr, DMA_REG_ADDR);
      src_rgn = decode_region(src_addr, DMA_REG_ADDR);
      cpu_wr  = rst && !dma_busy && !cpu_rw;

      // DMA reads from PPU, unmapped or the DMA register fall back to open bus.
      rgn_d = RGN_NONE;
      if (dma_busy) begin
         if (dma_rd && (src_rgn == RGN_RAM || src_rgn == RGN_PRG)) rgn_d = src_rgn;
      end else if (cpu_rw && cpu_rgn != RGN_DMA) begin
         rgn_d = cpu_rgn;
      end

      unique case (rgn_q)
         RGN_RAM: rd_mux = ram_rdata;
         RGN_PPU: rd_mux = ppu_rdata;
         RGN_PRG: rd_mux = prg_rdata;
         default: rd_mux = ob_q;
      endcase

      ob_d      = cpu_wr ? cpu_wdata : rd_mux;
      cpu_rdata = rd_mux;
      oam_wdata = rd_mux;
      cpu_rdy   = !dma_busy;

      ram_addr  = dma_busy ? src_addr[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];
      prg_addr  = dma_busy ? src_addr[14:0] : cpu_addr[14:0];
      ram_we    = cpu_wr && (cpu_rgn == RGN_RAM);
      ram_wdata = cpu_wdata;

      ppu_cs    = rst && !dma_busy && (cpu_rgn == RGN_PPU);
      ppu_we    = ppu_cs && !cpu_rw;
      ppu_reg   = cpu_addr[2:0];
      ppu_wdata = cpu_wdata;

      dma_start = cpu_wr && (cpu_rgn == RGN_DMA);
   end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed self-checking bench for cpu_bus_ctrl with simple RAM/PRG/PPU models.
module tb_cpu_bus_ctrl;

   logic        clk_ph1 = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cpu_addr = 16'h5000;
   logic        cpu_rw = 1'b1;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  cpu_rdata;
   logic        cpu_rdy;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic [14:0] prg_addr;
   logic [7:0]  prg_rdata = 8'h00;
   logic        ppu_cs;
   logic        ppu_we;
   logic [2:0]  ppu_reg;
   logic [7:0]  ppu_wdata;
   logic [7:0]  ppu_rdata = 8'h00;
   logic        oam_we;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_ph1 = ~clk_ph1;

   cpu_bus_ctrl #(.DMA_REG_ADDR(16'h4014), .RAM_AW(11)) dut (
      .clk_ph1(clk_ph1), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .prg_addr(prg_addr), .prg_rdata(prg_rdata),
      .ppu_cs(ppu_cs), .ppu_we(ppu_we), .ppu_reg(ppu_reg), .ppu_wdata(ppu_wdata),
      .ppu_rdata(ppu_rdata),
      .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata)
   );

   // RAM preload: [$005]=$A5, page 2 holds i, page 3 holds ~i, rest 0.
   function automatic logic [7:0] ram_init(input logic [10:0] a);
      if (a == 11'h005) return 8'hA5;
      if (a[10:8] == 3'h2) return a[7:0];
      if (a[10:8] == 3'h3) return a[7:0] ^ 8'hFF;
      return 8'h00;
   endfunction

   bit         wr_valid [0:2047];
   logic [7:0] wr_mem   [0:2047];

   always @(posedge clk_ph1) begin
      if (ram_we === 1'b1) begin
         wr_valid[ram_addr] <= 1'b1;
         wr_mem[ram_addr]   <= ram_wdata;
      end
      ram_rdata <= wr_valid[ram_addr] ? wr_mem[ram_addr] : ram_init(ram_addr);
   end

   always @(posedge clk_ph1)
      prg_rdata <= (prg_addr == 15'h0000) ? 8'h4C : (prg_addr[7:0] ^ 8'h33);

   always @(posedge clk_ph1)
      if (ppu_cs === 1'b1 && ppu_we === 1'b0) ppu_rdata <= {5'b01110, ppu_reg};

   task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
      @(posedge clk_ph1);
      #1;
      cpu_addr  = a;
      cpu_rw    = rw;
      cpu_wdata = d;
      #1;
   endtask

   task automatic run_dma(input logic [7:0] page, input logic inject, input logic use_const,
                          input logic [7:0] cval, input logic [7:0] mask,
                          output int stall, output int cnt, output int bad, output int viol);
      logic [7:0] exp_idx;
      exp_idx = 8'h00;
      stall = 0; cnt = 0; bad = 0; viol = 0;
      cyc(16'h4014, 1'b0, page);
      for (int k = 1; k <= 700; k++) begin
         if (inject && k == 10)      cyc(16'h4014, 1'b0, 8'h05);
         else if (inject && k == 20) cyc(16'h0000, 1'b0, 8'hEE);
         else                        cyc(16'h5000, 1'b1, 8'h00);
         if (cpu_rdy === 1'b1) break;
         stall++;
         if (ram_we !== 1'b0 || ppu_cs !== 1'b0) viol++;
         if (oam_we === 1'b1) begin
            cnt++;
            if (oam_addr !== exp_idx ||
                oam_wdata !== (use_const ? cval : (exp_idx ^ mask))) bad++;
            exp_idx++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc(16'h0000, 1'b0, 8'hFF);
      cyc(16'h0000, 1'b0, 8'hFF);
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
      n_cmp++; if (ppu_cs !== 1'b0 || ppu_we !== 1'b0) begin n_bad++; $display("FAIL rst_ppu: got cs=%b we=%b want 0", ppu_cs, ppu_we); end
      n_cmp++; if (oam_we !== 1'b0) begin n_bad++; $display("FAIL rst_oam_we: got %b want 0", oam_we); end
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %b want 1", cpu_rdy); end
      n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", cpu_rdata); end
      cpu_rw   = 1'b1;
      cpu_addr = 16'h5000;
      rst      = 1'b1;
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_open_bus: got %h want 00", cpu_rdata); end
   endtask

   task automatic test_ram();
      cyc(16'h0805, 1'b1, 8'h00);
      n_cmp++; if (ram_addr !== 11'h005) begin n_bad++; $display("FAIL ram_mirror_addr: got %h want 005", ram_addr); end
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL ram_read_we: got %b want 0", ram_we); end
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL ram_read_data: got %h want a5", cpu_rdata); end
      cyc(16'h0F10, 1'b0, 8'h5A);
      n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 11'h710 || ram_wdata !== 8'h5A) begin
         n_bad++; $display("FAIL ram_write: got we=%b addr=%h data=%h want 1/710/5a", ram_we, ram_addr, ram_wdata); end
      n_cmp++; if (ppu_cs !== 1'b0) begin n_bad++; $display("FAIL ram_write_ppu_cs: got %b want 0", ppu_cs); end
      cyc(16'h0710, 1'b1, 8'h00);
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'h5A) begin n_bad++; $display("FAIL ram_readback: got %h want 5a", cpu_rdata); end
   endtask

   task automatic test_ppu();
      cyc(16'h3FFA, 1'b0, 8'h3C);
      n_cmp++; if (ppu_cs !== 1'b1 || ppu_we !== 1'b1 || ppu_reg !== 3'd2 || ppu_wdata !== 8'h3C) begin
         n_bad++; $display("FAIL ppu_write: got cs=%b we=%b reg=%0d data=%h want 1/1/2/3c", ppu_cs, ppu_we, ppu_reg, ppu_wdata); end
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL ppu_write_ram_we: got %b want 0", ram_we); end
      cyc(16'h2007, 1'b1, 8'h00);
      n_cmp++; if (ppu_cs !== 1'b1 || ppu_we !== 1'b0 || ppu_reg !== 3'd7) begin
         n_bad++; $display("FAIL ppu_read_strobe: got cs=%b we=%b reg=%0d want 1/0/7", ppu_cs, ppu_we, ppu_reg); end
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (ppu_cs !== 1'b0) begin n_bad++; $display("FAIL ppu_cs_one_cycle: got %b want 0", ppu_cs); end
      n_cmp++; if (cpu_rdata !== 8'h77) begin n_bad++; $display("FAIL ppu_read_data: got %h want 77", cpu_rdata); end
   endtask

   task automatic test_prg_open_bus();
      cyc(16'h8000, 1'b1, 8'h00);
      n_cmp++; if (prg_addr !== 15'h0000) begin n_bad++; $display("FAIL prg_addr: got %h want 0000", prg_addr); end
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'h4C) begin n_bad++; $display("FAIL prg_read: got %h want 4c", cpu_rdata); end
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'h4C) begin n_bad++; $display("FAIL open_bus_hold: got %h want 4c", cpu_rdata); end
      cyc(16'h8000, 1'b0, 8'h99);
      n_cmp++; if (ram_we !== 1'b0 || ppu_cs !== 1'b0) begin n_bad++; $display("FAIL prg_write_ignored: got ram_we=%b ppu_cs=%b want 0/0", ram_we, ppu_cs); end
      cyc(16'h4014, 1'b1, 8'h00);
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'h99) begin n_bad++; $display("FAIL dma_reg_read_open_bus: got %h want 99", cpu_rdata); end
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL dma_reg_read_no_start: got %b want 1", cpu_rdy); end
      cyc(16'hFFFF, 1'b1, 8'h00);
      n_cmp++; if (prg_addr !== 15'h7FFF) begin n_bad++; $display("FAIL prg_top_addr: got %h want 7fff", prg_addr); end
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdata !== 8'hCC) begin n_bad++; $display("FAIL prg_top_data: got %h want cc", cpu_rdata); end
   endtask

   task automatic test_dma_full();
      int stall, cnt, bad, viol;
      run_dma(8'h02, 1'b0, 1'b0, 8'h00, 8'h00, stall, cnt, bad, viol);
      n_cmp++; if (stall !== 513) begin n_bad++; $display("FAIL dma_stall: got %0d want 513", stall); end
      n_cmp++; if (cnt !== 256) begin n_bad++; $display("FAIL dma_oam_we_count: got %0d want 256", cnt); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL dma_oam_data: got %0d bad writes want 0", bad); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL dma_cpu_strobes: got %0d want 0", viol); end
      n_cmp++; if (oam_we !== 1'b0) begin n_bad++; $display("FAIL dma_done_oam_we: got %b want 0", oam_we); end
   endtask

   task automatic test_dma_ppu_page();
      int stall, cnt, bad, viol;
      run_dma(8'h20, 1'b0, 1'b1, 8'h20, 8'h00, stall, cnt, bad, viol);
      n_cmp++; if (stall !== 513 || cnt !== 256) begin n_bad++; $display("FAIL dma_ppu_page_len: got stall=%0d cnt=%0d want 513/256", stall, cnt); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL dma_ppu_page_open_bus: got %0d bad writes want 0", bad); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL dma_ppu_page_cs: got %0d want 0", viol); end
   endtask

   task automatic test_dma_rewrite();
      int stall, cnt, bad, viol;
      run_dma(8'h03, 1'b1, 1'b0, 8'h00, 8'hFF, stall, cnt, bad, viol);
      n_cmp++; if (stall !== 513) begin n_bad++; $display("FAIL dma_rewrite_stall: got %0d want 513", stall); end
      n_cmp++; if (cnt !== 256 || bad !== 0) begin n_bad++; $display("FAIL dma_rewrite_data: got cnt=%0d bad=%0d want 256/0", cnt, bad); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL dma_rewrite_strobes: got %0d want 0", viol); end
      cyc(16'h5000, 1'b1, 8'h00);
      cyc(16'h5000, 1'b1, 8'h00);
      cyc(16'h5000, 1'b1, 8'h00);
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL dma_rewrite_no_restart: got %b want 1", cpu_rdy); end
   endtask

   task automatic test_dma_abort();
      int pre, post, stalled, stall, cnt, bad, viol;
      pre = 0; post = 0; stalled = 0;
      cyc(16'h4014, 1'b0, 8'h02);
      for (int k = 1; k <= 100; k++) begin
         cyc(16'h5000, 1'b1, 8'h00);
         if (oam_we === 1'b1) pre++;
      end
      rst = 1'b0;
      cyc(16'h5000, 1'b1, 8'h00);
      rst = 1'b1;
      n_cmp++; if (pre !== 49) begin n_bad++; $display("FAIL abort_pre_count: got %0d want 49", pre); end
      n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL abort_rdy: got %b want 1", cpu_rdy); end
      n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL abort_rdata: got %h want 00", cpu_rdata); end
      for (int k = 0; k < 600; k++) begin
         cyc(16'h5000, 1'b1, 8'h00);
         if (oam_we !== 1'b0) post++;
         if (cpu_rdy !== 1'b1) stalled++;
      end
      n_cmp++; if (post !== 0 || stalled !== 0) begin n_bad++; $display("FAIL abort_quiet: got oam_we=%0d stalled=%0d want 0/0", post, stalled); end
      run_dma(8'h02, 1'b0, 1'b0, 8'h00, 8'h00, stall, cnt, bad, viol);
      n_cmp++; if (stall !== 513 || cnt !== 256) begin n_bad++; $display("FAIL abort_restart_len: got stall=%0d cnt=%0d want 513/256", stall, cnt); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL abort_restart_idx: got %0d bad writes want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_ppu();
      test_prg_open_bus();
      test_dma_full();
      test_dma_ppu_page();
      test_dma_rewrite();
      test_dma_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
